// File: rtl/debug_pkg.sv
// Shared types and constants for the debug snapshot unit.
package debug_pkg;

  typedef enum logic {
    DBG_IDLE,
    DBG_STREAM
  } dbg_state_e;

  localparam int unsigned DBG_MISS_W = 8;
  localparam logic [DBG_MISS_W-1:0] DBG_MISS_MAX = '1;

endpackage

// File: rtl/debug_watch_cmp.sv
// Combinational PC/address watchpoint comparator.
module debug_watch_cmp #(
  parameter int unsigned XLEN = 32
) (
  input  logic            watch_en,
  input  logic            retire,
  input  logic [XLEN-1:0] retire_pc,
  input  logic [XLEN-1:0] watch_pc,
  output logic            watch_hit
);

  // Hit only when enabled and an instruction at the watched address retires
  always_comb begin
    watch_hit = watch_en & retire & (retire_pc == watch_pc);
  end

endmodule

// File: rtl/debug_reg_snapshot.sv
// Register file snapshot: single-cycle parallel capture, then a
// valid/ready stream of index-tagged words.
module debug_reg_snapshot
  import debug_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREGS = 32,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned IDX_W = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREGS*XLEN-1:0] regs_flat,
  input  logic                  retire,
  input  logic [XLEN-1:0]       retire_pc,
  input  logic                  snap_req,
  input  logic                  watch_en,
  input  logic [XLEN-1:0]       watch_pc,
  input  logic                  skip_x0,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_data,
  output logic [IDX_W-1:0]      out_idx,
  output logic                  out_last,
  output logic                  busy,
  output logic [CNT_W-1:0]      snap_count,
  output logic [DBG_MISS_W-1:0] miss_count
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NREGS - 1);

  dbg_state_e state_q, state_d;

  logic [XLEN-1:0]       snap_q [NREGS];
  logic [IDX_W-1:0]      idx_q;
  logic [XLEN-1:0]       data_q;
  logic                  last_q;
  logic [CNT_W-1:0]      snap_cnt_q;
  logic [DBG_MISS_W-1:0] miss_q;

  logic                  watch_hit;
  logic                  trigger;
  logic                  load;
  logic                  miss_inc;
  logic                  advance;
  logic [IDX_W-1:0]      start_idx;
  logic [XLEN-1:0]       start_word;
  logic [IDX_W-1:0]      idx_nxt;

  debug_watch_cmp #(
    .XLEN (XLEN)
  ) u_watch_cmp (
    .watch_en  (watch_en),
    .retire    (retire),
    .retire_pc (retire_pc),
    .watch_pc  (watch_pc),
    .watch_hit (watch_hit)
  );

  // Trigger decode and per-beat helper values
  always_comb begin
    trigger    = snap_req | watch_hit;
    start_idx  = skip_x0 ? IDX_W'(1) : '0;
    start_word = skip_x0 ? regs_flat[XLEN +: XLEN] : regs_flat[0 +: XLEN];
    idx_nxt    = idx_q + 1'b1;
    advance    = (state_q == DBG_STREAM) & out_ready & ~last_q;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= DBG_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state; a trigger on the final handshake recaptures without a bubble
  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    miss_inc = 1'b0;
    case (state_q)
      DBG_IDLE: begin
        if (trigger) begin
          load    = 1'b1;
          state_d = DBG_STREAM;
        end
      end
      DBG_STREAM: begin
        if (out_ready && last_q) begin
          if (trigger) begin
            load = 1'b1;
          end else begin
            state_d = DBG_IDLE;
          end
        end else if (trigger) begin
          miss_inc = 1'b1;
        end
      end
      default: state_d = DBG_IDLE;
    endcase
  end

  // Frozen copy of the register file; contents are don't-care out of reset
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NREGS; i++) begin
        snap_q[i] <= regs_flat[i*XLEN +: XLEN];
      end
    end
  end

  // Registered beat fields and counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      snap_cnt_q <= '0;
      miss_q     <= '0;
    end else begin
      if (load) begin
        // First beat comes straight from the live file, as the buffer loads in parallel
        idx_q      <= start_idx;
        data_q     <= start_word;
        last_q     <= (start_idx == LastIdx);
        snap_cnt_q <= snap_cnt_q + 1'b1;
      end else if (advance) begin
        idx_q  <= idx_nxt;
        data_q <= snap_q[idx_nxt];
        last_q <= (idx_nxt == LastIdx);
      end else if (state_d == DBG_IDLE) begin
        last_q <= 1'b0;
      end
      if (miss_inc && (miss_q != DBG_MISS_MAX)) begin
        miss_q <= miss_q + 1'b1;
      end
    end
  end

  // Outputs are straight from flops
  always_comb begin
    out_valid  = (state_q == DBG_STREAM);
    busy       = (state_q == DBG_STREAM);
    out_data   = data_q;
    out_idx    = idx_q;
    out_last   = last_q;
    snap_count = snap_cnt_q;
    miss_count = miss_q;
  end

endmodule

// File: tb/tb_debug_reg_snapshot.sv
// Directed bench for debug_reg_snapshot with hand-computed expectations.
module tb_debug_reg_snapshot;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREGS*XLEN-1:0] regs_flat = '0;
  logic                  retire = 1'b0;
  logic [XLEN-1:0]       retire_pc = '0;
  logic                  snap_req = 1'b0;
  logic                  watch_en = 1'b0;
  logic [XLEN-1:0]       watch_pc = '0;
  logic                  skip_x0 = 1'b0;
  logic                  out_valid;
  logic                  out_ready = 1'b1;
  logic [XLEN-1:0]       out_data;
  logic [4:0]            out_idx;
  logic                  out_last;
  logic                  busy;
  logic [15:0]           snap_count;
  logic [7:0]            miss_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  debug_reg_snapshot dut (
    .clk        (clk),
    .rst        (rst),
    .regs_flat  (regs_flat),
    .retire     (retire),
    .retire_pc  (retire_pc),
    .snap_req   (snap_req),
    .watch_en   (watch_en),
    .watch_pc   (watch_pc),
    .skip_x0    (skip_x0),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_idx    (out_idx),
    .out_last   (out_last),
    .busy       (busy),
    .snap_count (snap_count),
    .miss_count (miss_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_regs(input logic [31:0] base);
    for (int i = 0; i < NREGS; i++) regs_flat[i*XLEN +: XLEN] = base + i;
  endtask

  task automatic drain(input string tag);
    for (int n = 0; n < 80 && busy; n++) tick();
    chk(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    set_regs(32'h1000_0000);

    // Reset state
    tick();
    chk("rst_valid", {31'd0, out_valid}, 0);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_last", {31'd0, out_last}, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", {27'd0, out_idx}, 0);
    chk("rst_snap", {16'd0, snap_count}, 0);
    chk("rst_miss", {24'd0, miss_count}, 0);
    rst = 1'b0;
    tick();
    chk("idle_valid", {31'd0, out_valid}, 0);

    // Full snapshot, ready held high
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      chk("t1_valid", {31'd0, out_valid}, 1);
      chk("t1_idx", {27'd0, out_idx}, i);
      chk("t1_data", out_data, 32'h1000_0000 + i);
      chk("t1_last", {31'd0, out_last}, (i == 31) ? 1 : 0);
      tick();
    end
    chk("t1_busy_low", {31'd0, busy}, 0);
    chk("t1_valid_low", {31'd0, out_valid}, 0);
    chk("t1_snap", {16'd0, snap_count}, 1);

    // skip_x0 with stalls; live file changes mid-stream
    skip_x0  = 1'b1;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    skip_x0  = 1'b0;
    for (int j = 1; j < NREGS; j++) begin
      out_ready = 1'b0;
      chk("t2_idx", {27'd0, out_idx}, j);
      chk("t2_data", out_data, 32'h1000_0000 + j);
      if (j == 5) set_regs(32'hDEAD_0000);
      tick();
      chk("t2_hold_valid", {31'd0, out_valid}, 1);
      chk("t2_hold_idx", {27'd0, out_idx}, j);
      chk("t2_hold_data", out_data, 32'h1000_0000 + j);
      chk("t2_hold_last", {31'd0, out_last}, (j == 31) ? 1 : 0);
      out_ready = 1'b1;
      tick();
    end
    chk("t2_busy_low", {31'd0, busy}, 0);
    chk("t2_snap", {16'd0, snap_count}, 2);

    // PC watchpoint
    watch_en  = 1'b1;
    watch_pc  = 32'h0000_0040;
    retire    = 1'b1;
    retire_pc = 32'h0000_003C;
    tick();
    chk("w_miss_pc_busy", {31'd0, busy}, 0);
    chk("w_miss_pc_snap", {16'd0, snap_count}, 2);
    retire_pc = 32'h0000_0040;
    tick();
    retire = 1'b0;
    chk("w_hit_busy", {31'd0, busy}, 1);
    chk("w_hit_snap", {16'd0, snap_count}, 3);
    chk("w_hit_idx", {27'd0, out_idx}, 0);
    chk("w_hit_data", out_data, 32'hDEAD_0000);
    drain("w_drain");
    watch_en = 1'b0;
    retire   = 1'b1;
    tick();
    retire = 1'b0;
    chk("w_dis_busy", {31'd0, busy}, 0);
    chk("w_dis_snap", {16'd0, snap_count}, 3);

    // Dropped triggers while streaming
    snap_req = 1'b1;
    tick();
    snap_req  = 1'b0;
    out_ready = 1'b0;
    chk("m_snap", {16'd0, snap_count}, 4);
    for (int k = 0; k < 3; k++) begin
      snap_req = 1'b1;
      tick();
      snap_req = 1'b0;
      tick();
    end
    chk("m_miss3", {24'd0, miss_count}, 3);
    chk("m_snap_keep", {16'd0, snap_count}, 4);

    // Trigger on the final handshake restarts with fresh data
    set_regs(32'h2000_0000);
    out_ready = 1'b1;
    repeat (31) tick();
    chk("f_idx31", {27'd0, out_idx}, 31);
    chk("f_last", {31'd0, out_last}, 1);
    chk("f_old_data", out_data, 32'hDEAD_001F);
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    chk("f_valid", {31'd0, out_valid}, 1);
    chk("f_idx0", {27'd0, out_idx}, 0);
    chk("f_data0", out_data, 32'h2000_0000);
    chk("f_snap", {16'd0, snap_count}, 5);
    chk("f_miss", {24'd0, miss_count}, 3);
    tick();
    chk("f_idx1", {27'd0, out_idx}, 1);
    chk("f_data1", out_data, 32'h2000_0001);

    // Miss counter saturation, stream held
    out_ready = 1'b0;
    snap_req  = 1'b1;
    repeat (251) tick();
    chk("s_miss254", {24'd0, miss_count}, 254);
    repeat (49) tick();
    snap_req = 1'b0;
    chk("s_miss255", {24'd0, miss_count}, 255);
    chk("s_snap", {16'd0, snap_count}, 5);

    // Async reset mid-cycle at beat 10
    out_ready = 1'b1;
    repeat (9) tick();
    chk("r_idx10", {27'd0, out_idx}, 10);
    #2;
    rst = 1'b1;
    #1;
    chk("r_valid", {31'd0, out_valid}, 0);
    chk("r_busy", {31'd0, busy}, 0);
    chk("r_idx", {27'd0, out_idx}, 0);
    chk("r_data", out_data, 0);
    chk("r_last", {31'd0, out_last}, 0);
    chk("r_snap", {16'd0, snap_count}, 0);
    chk("r_miss", {24'd0, miss_count}, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("r_post_valid", {31'd0, out_valid}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/debug_reg_snapshot.md
# debug_reg_snapshot

Parametrised debug snapshot unit for the rv32 pipeline. It captures the whole architectural register file in one cycle, on request or on a PC watchpoint hit at retirement. It then streams the frozen copy out one register per beat over a valid/ready handshake. It sits beside the register file in `src/units/debug/`, and replaces flat per-register taps with a buffered, index-tagged readout that a host bridge or trace FIFO can drain at its own rate.

## Interface
Parameters:
- `XLEN`, 32, register width in bits
- `NREGS`, 32, number of registers captured (≥2)
- `CNT_W`, 16, width of snapshot counter
- `IDX_W`, `$clog2(NREGS)`, derived, not overridden

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `regs_flat`  in  NREGS*XLEN  live register file, register i at bits [i*XLEN +: XLEN]
- `retire`  in  1  an instruction retires this cycle
- `retire_pc`  in  XLEN  PC of the retiring instruction
- `snap_req`  in  1  software/host snapshot request, single-cycle pulse or level
- `watch_en`  in  1  enable PC watchpoint
- `watch_pc`  in  XLEN  watchpoint address
- `skip_x0`  in  1  when 1, stream starts at index 1; sampled at capture
- `out_valid`  out  1  beat valid
- `out_ready`  in  1  sink accepts beat
- `out_data`  out  XLEN  captured register value
- `out_idx`  out  IDX_W  register index of beat
- `out_last`  out  1  final beat of snapshot
- `busy`  out  1  snapshot held or streaming
- `snap_count`  out  CNT_W  snapshots captured, wraps
- `miss_count`  out  8  triggers dropped while busy, saturates at 255

## Operation
- trigger = `snap_req` | (`watch_en` & `retire` & `retire_pc` == `watch_pc`).
- States: IDLE, STREAM.
- IDLE: `out_valid`=0. On trigger:
  - copy all NREGS words into the snapshot buffer
  - latch `skip_x0`
  - set the index to 1 if the latch is set, else 0
  - `snap_count`+1, go to STREAM.
- STREAM:
  - `out_valid`=1, `out_data`=buffer[idx], `out_idx`=idx, `out_last`=(idx==NREGS-1).
  - A handshake (`out_valid`&`out_ready`) advances idx by 1.
  - Handshake with `out_last` returns to IDLE.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_idx` and `out_last` hold stable.
- Live `regs_flat` changes never affect a snapshot in progress.
- Trigger in STREAM, other than on the final handshake cycle: dropped, `miss_count`+1 (saturating). `snap_count` unchanged.
- Trigger in the same cycle as the final handshake:
  - accepted, recapture from the current `regs_flat`
  - stay in STREAM, idx restarts per the new `skip_x0`
  - no IDLE bubble, no miss.
- `busy` = (state==STREAM).
- `snap_count` wraps 2^CNT_W-1 → 0.

## Timing
- Reset (async assert; release synchronous to `clk`):
  - state IDLE; `out_valid`, `out_last`, `busy` = 0
  - `out_data`, `out_idx` = 0
  - `snap_count`, `miss_count` = 0
  - buffer contents don't-care.
- Reset asserted mid-stream aborts immediately. No further beats after release until a new trigger.
- Capture latency: `regs_flat` sampled on the trigger edge. First beat `out_valid`=1 in the following cycle.
- Throughput: one beat per cycle with `out_ready` held high.
  - Full snapshot = NREGS beats, or NREGS-1 with `skip_x0`.
  - Trigger to `busy` low = beats+1 cycles.
- Counters update on the same edge as the capture or drop that causes them.
- `out_*` are registered outputs. There is no combinational path from `out_ready` to `out_valid` or `out_data`.

## Structure
- Package `debug_pkg`:
  - `dbg_state_e` enum {DBG_IDLE, DBG_STREAM}
  - `DBG_MISS_W`=8 and its saturation constant.
- Sub-module `debug_watch_cmp`: registered-free comparator producing `watch_hit` from `watch_en`, `retire`, `retire_pc` and `watch_pc`. It is reused later for data watchpoints.
- Buffer: NREGS×XLEN flops. A mux on idx produces `out_data`. No RAM, since the capture needs a single-cycle parallel load.

## Test plan
- Reset release, `regs_flat` word i = 0x1000_0000+i, `snap_req` pulse, `out_ready`=1:
  - 32 consecutive beats, idx 0..31, data 0x1000_0000..0x1000_001F
  - `out_last` only on idx 31
  - `busy` low 33 cycles after the trigger
  - `snap_count`=1.
- `skip_x0`=1, `out_ready` toggled 1/0 every cycle:
  - 31 beats, idx 1..31
  - data/idx stable across every stalled cycle
  - `regs_flat` changed mid-stream has no effect on output.
- `watch_en`=1, `watch_pc`=0x0000_0040:
  - `retire`=1 with pc 0x3C: no capture
  - `retire`=1 with pc 0x40: capture the next cycle
  - `watch_en`=0 with pc 0x40: no capture.
- Triggers in STREAM:
  - 3 `snap_req` pulses mid-stream → `miss_count`=3, `snap_count` unchanged
  - 300 pulses → `miss_count` saturates at 255
  - `snap_req` on the final-handshake cycle → new stream starts the next cycle at idx 0 with the new data, `miss_count` unchanged.
- Async `rst` pulse mid-cycle during beat idx 10:
  - outputs and counters drop to 0 immediately
  - after release, `out_valid` stays 0 until the next trigger.
